// File: rtl/ahb_pkg.sv
// Shared AHB3-Lite encodings and the data-phase record used by the initiator.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   typedef struct packed {
      logic       valid;
      logic       write;
      logic [1:0] size;
      logic [1:0] addr_lo;
      logic       local_err;
   } ahb_dphase_t;

   // A request may reach the bus only if its size is legal and naturally aligned.
   function automatic logic req_legal(input logic [1:0] size, input logic [1:0] addr_lo);
      case ({1'b0, size})
         HSIZE_BYTE: req_legal = 1'b1;
         HSIZE_HALF: req_legal = ~addr_lo[0];
         HSIZE_WORD: req_legal = (addr_lo == 2'b00);
         default:    req_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Write-lane placement and read-lane extraction for 32-bit AHB data.
// AHB_INITIATOR_LANE_REPLICATE_EN replicates narrow write data across all lanes.
module ahb_lane_align
   import ahb_pkg::*;
(
   input  logic [1:0]  wr_size,
   input  logic [1:0]  wr_addr_lo,
   input  logic [31:0] wr_data,
   output logic [31:0] wr_lanes,
   input  logic [1:0]  rd_size,
   input  logic [1:0]  rd_addr_lo,
   input  logic [31:0] rd_data,
   output logic [31:0] rd_value
);

   logic [31:0] rd_shifted;

`ifdef AHB_INITIATOR_LANE_REPLICATE_EN
   logic unused_wr_addr;
   assign unused_wr_addr = ^wr_addr_lo;

   always_comb begin
      wr_lanes = wr_data;
      case ({1'b0, wr_size})
         HSIZE_BYTE: wr_lanes = {4{wr_data[7:0]}};
         HSIZE_HALF: wr_lanes = {2{wr_data[15:0]}};
         default:    wr_lanes = wr_data;
      endcase
   end
`else
   always_comb begin
      wr_lanes = wr_data;
      case ({1'b0, wr_size})
         HSIZE_BYTE: wr_lanes = {24'h0, wr_data[7:0]} << {wr_addr_lo, 3'b000};
         HSIZE_HALF: wr_lanes = wr_addr_lo[1] ? {wr_data[15:0], 16'h0} : {16'h0, wr_data[15:0]};
         default:    wr_lanes = wr_data;
      endcase
   end
`endif

   assign rd_shifted = rd_data >> {rd_addr_lo, 3'b000};

   always_comb begin
      rd_value = rd_shifted;
      case ({1'b0, rd_size})
         HSIZE_BYTE: rd_value = {24'h0, rd_shifted[7:0]};
         HSIZE_HALF: rd_value = {16'h0, rd_shifted[15:0]};
         default:    rd_value = rd_shifted;
      endcase
   end

endmodule

// File: rtl/ahb_lite_initiator.sv
// AHB3-Lite initiator: valid/ready requests become single NONSEQ transfers, one response each.
// Build option AHB_INITIATOR_LANE_REPLICATE_EN selects replicated write lanes (see ahb_lane_align).
module ahb_lite_initiator
   import ahb_pkg::*;
#(
   parameter int         AW    = 32,
   parameter logic [3:0] HPROT = 4'b0011
) (
   input  logic          s_clk_i,
   input  logic          s_reset_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic [AW-1:0] req_addr_i,
   input  logic          req_write_i,
   input  logic [1:0]    req_size_i,
   input  logic [31:0]   req_wdata_i,
   output logic          rsp_valid_o,
   output logic [31:0]   rsp_rdata_o,
   output logic          rsp_err_o,
   output logic [AW-1:0] m_haddr_o,
   output logic [1:0]    m_htrans_o,
   output logic          m_hwrite_o,
   output logic [2:0]    m_hsize_o,
   output logic [2:0]    m_hburst_o,
   output logic          m_hmastlock_o,
   output logic [3:0]    m_hprot_o,
   output logic [31:0]   m_hwdata_o,
   input  logic [31:0]   m_hrdata_i,
   input  logic          m_hready_i,
   input  logic          m_hresp_i
);

   ahb_dphase_t dp;
   logic [31:0] wr_lanes;
   logic [31:0] rd_value;
   logic        req_ok;
   logic        err_mask;
   logic        accept;
   logic        complete;

   ahb_lane_align u_lane_align (
      .wr_size    (req_size_i),
      .wr_addr_lo (req_addr_i[1:0]),
      .wr_data    (req_wdata_i),
      .wr_lanes   (wr_lanes),
      .rd_size    (dp.size),
      .rd_addr_lo (dp.addr_lo),
      .rd_data    (m_hrdata_i),
      .rd_value   (rd_value)
   );

   assign req_ok = req_legal(req_size_i, req_addr_i[1:0]);

   // Blocks acceptance and the next address phase across both ERROR response cycles.
   assign err_mask = dp.valid & m_hresp_i;

   assign req_ready_o = m_hready_i & ~err_mask & ~s_reset_i;
   assign accept      = req_valid_i & req_ready_o;
   assign complete    = dp.valid & m_hready_i;

   assign m_haddr_o     = req_addr_i;
   assign m_hwrite_o    = req_write_i;
   assign m_hsize_o     = {1'b0, req_size_i};
   assign m_hburst_o    = HBURST_SINGLE;
   assign m_hmastlock_o = 1'b0;
   assign m_hprot_o     = HPROT;
   assign m_htrans_o    = (req_valid_i & req_ok & ~err_mask & ~s_reset_i) ? HTRANS_NONSEQ
                                                                          : HTRANS_IDLE;

   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         dp          <= '0;
         m_hwdata_o  <= '0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_rdata_o <= '0;
      end else begin
         rsp_valid_o <= complete;
         rsp_err_o   <= complete & (m_hresp_i | dp.local_err);
         rsp_rdata_o <= (complete & ~dp.write & ~m_hresp_i & ~dp.local_err) ? rd_value : '0;

         // Misaligned/illegal requests take the data-phase slot so their error returns in order.
         if (accept) begin
            dp <= '{valid:     1'b1,
                    write:     req_write_i,
                    size:      req_size_i,
                    addr_lo:   req_addr_i[1:0],
                    local_err: ~req_ok};
            m_hwdata_o <= wr_lanes;
         end else if (complete) begin
            dp.valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ahb_lite_initiator.sv
// Directed scenarios plus a randomized run against a transaction-level model with a memory-backed slave.
module tb_ahb_lite_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic        hmastlock;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   ahb_lite_initiator #(.AW(32), .HPROT(4'b0011)) dut (
      .s_clk_i       (clk),
      .s_reset_i     (rst),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_addr_i    (req_addr),
      .req_write_i   (req_write),
      .req_size_i    (req_size),
      .req_wdata_i   (req_wdata),
      .rsp_valid_o   (rsp_valid),
      .rsp_rdata_o   (rsp_rdata),
      .rsp_err_o     (rsp_err),
      .m_haddr_o     (haddr),
      .m_htrans_o    (htrans),
      .m_hwrite_o    (hwrite),
      .m_hsize_o     (hsize),
      .m_hburst_o    (hburst),
      .m_hmastlock_o (hmastlock),
      .m_hprot_o     (hprot),
      .m_hwdata_o    (hwdata),
      .m_hrdata_i    (hrdata),
      .m_hready_i    (hready),
      .m_hresp_i     (hresp)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0;
      req_addr  = '0;
      req_write = 1'b0;
      req_size  = 2'd0;
      req_wdata = '0;
      hrdata    = '0;
      hready    = 1'b1;
      hresp     = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drive_req(input logic [31:0] a, input logic w, input logic [1:0] s,
                            input logic [31:0] d);
      req_valid = 1'b1;
      req_addr  = a;
      req_write = w;
      req_size  = s;
      req_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      drive_req(32'h10, 1'b0, 2'd2, 32'h0);
      mid();
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %0h exp 0", rsp_valid); end
      vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got %0h exp 0", rsp_err); end
      vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_rdata got %08h exp 0", rsp_rdata); end
      vectors++; if (hwdata !== 32'h0) begin miscompares++; $display("FAIL reset_hwdata got %08h exp 0", hwdata); end
      vectors++; if (htrans !== 2'd0) begin miscompares++; $display("FAIL reset_htrans got %0h exp 0", htrans); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready got %0h exp 0", req_ready); end
      vectors++; if (hburst !== 3'd0) begin miscompares++; $display("FAIL hburst got %0h exp 0", hburst); end
      vectors++; if (hmastlock !== 1'b0) begin miscompares++; $display("FAIL hmastlock got %0h exp 0", hmastlock); end
      vectors++; if (hprot !== 4'b0011) begin miscompares++; $display("FAIL hprot got %0h exp 3", hprot); end
      step();
      rst = 1'b0;
      req_valid = 1'b0;
   endtask

   task automatic test_word_write();
      do_reset();
      drive_req(32'h0000_0010, 1'b1, 2'd2, 32'hDEAD_BEEF);
      mid();
      vectors++; if (htrans !== 2'd2) begin miscompares++; $display("FAIL ww_htrans got %0h exp 2", htrans); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ww_ready got %0h exp 1", req_ready); end
      vectors++; if (haddr !== 32'h10) begin miscompares++; $display("FAIL ww_haddr got %08h exp 00000010", haddr); end
      vectors++; if (hwrite !== 1'b1) begin miscompares++; $display("FAIL ww_hwrite got %0h exp 1", hwrite); end
      vectors++; if (hsize !== 3'd2) begin miscompares++; $display("FAIL ww_hsize got %0h exp 2", hsize); end
      step();
      req_valid = 1'b0;
      mid();
      vectors++; if (hwdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL ww_hwdata got %08h exp deadbeef", hwdata); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ww_rsp_early got %0h exp 0", rsp_valid); end
      step();
      mid();
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL ww_rsp_valid got %0h exp 1", rsp_valid); end
      vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL ww_rsp_err got %0h exp 0", rsp_err); end
      step();
      mid();
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ww_rsp_pulse got %0h exp 0", rsp_valid); end
   endtask

   task automatic test_byte_read_wait();
      do_reset();
      drive_req(32'h0000_0103, 1'b0, 2'd0, 32'h0);
      mid();
      vectors++; if (htrans !== 2'd2) begin miscompares++; $display("FAIL br_htrans got %0h exp 2", htrans); end
      step();
      drive_req(32'h0000_0200, 1'b0, 2'd2, 32'h0);
      hready = 1'b0;
      for (int w = 0; w < 2; w++) begin
         mid();
         vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL br_wait%0d_ready got %0h exp 0", w, req_ready); end
         vectors++; if (htrans !== 2'd2) begin miscompares++; $display("FAIL br_wait%0d_htrans got %0h exp 2", w, htrans); end
         vectors++; if (haddr !== 32'h200) begin miscompares++; $display("FAIL br_wait%0d_haddr got %08h exp 00000200", w, haddr); end
         vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL br_wait%0d_rsp got %0h exp 0", w, rsp_valid); end
         step();
      end
      hready = 1'b1;
      hrdata = 32'hAABB_CCDD;
      mid();
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL br_ready_after got %0h exp 1", req_ready); end
      step();
      req_valid = 1'b0;
      hrdata = 32'h1234_5678;
      mid();
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL br_rsp_valid got %0h exp 1", rsp_valid); end
      vectors++; if (rsp_rdata !== 32'h0000_00AA) begin miscompares++; $display("FAIL br_rsp_rdata got %08h exp 000000aa", rsp_rdata); end
      vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL br_rsp_err got %0h exp 0", rsp_err); end
      step();
      hrdata = 32'h0;
      mid();
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL br2_rsp_valid got %0h exp 1", rsp_valid); end
      vectors++; if (rsp_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL br2_rsp_rdata got %08h exp 12345678", rsp_rdata); end
      step();
      mid();
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL br_rsp_end got %0h exp 0", rsp_valid); end
   endtask

   task automatic test_half_write();
      logic [31:0] exp_data;
`ifdef AHB_INITIATOR_LANE_REPLICATE_EN
      exp_data = 32'hBEEF_BEEF;
`else
      exp_data = 32'hBEEF_0000;
`endif
      do_reset();
      drive_req(32'h0000_0302, 1'b1, 2'd1, 32'h1234_BEEF);
      mid();
      vectors++; if (htrans !== 2'd2) begin miscompares++; $display("FAIL hw_htrans got %0h exp 2", htrans); end
      vectors++; if (hsize !== 3'd1) begin miscompares++; $display("FAIL hw_hsize got %0h exp 1", hsize); end
      step();
      req_valid = 1'b0;
      mid();
      vectors++; if (hwdata !== exp_data) begin miscompares++; $display("FAIL hw_hwdata got %08h exp %08h", hwdata, exp_data); end
      step();
      mid();
      vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL hw_rsp got v=%0h e=%0h exp v=1 e=0", rsp_valid, rsp_err); end
   endtask

   task automatic test_error_back_to_back();
      do_reset();
      drive_req(32'h0000_0040, 1'b0, 2'd2, 32'h0);
      mid();
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL er_first_ready got %0h exp 1", req_ready); end
      step();
      drive_req(32'h0000_0044, 1'b0, 2'd2, 32'h0);
      hready = 1'b0;
      hresp  = 1'b1;
      mid();
      vectors++; if (htrans !== 2'd0) begin miscompares++; $display("FAIL er_cyc1_htrans got %0h exp 0", htrans); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL er_cyc1_ready got %0h exp 0", req_ready); end
      step();
      hready = 1'b1;
      hresp  = 1'b1;
      hrdata = 32'hFFFF_FFFF;
      mid();
      vectors++; if (htrans !== 2'd0) begin miscompares++; $display("FAIL er_cyc2_htrans got %0h exp 0", htrans); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL er_cyc2_ready got %0h exp 0", req_ready); end
      step();
      hresp = 1'b0;
      mid();
      vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin miscompares++; $display("FAIL er_rsp got v=%0h e=%0h exp v=1 e=1", rsp_valid, rsp_err); end
      vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL er_rsp_rdata got %08h exp 0", rsp_rdata); end
      vectors++; if (htrans !== 2'd2 || req_ready !== 1'b1) begin miscompares++; $display("FAIL er_reissue got t=%0h r=%0h exp t=2 r=1", htrans, req_ready); end
      step();
      req_valid = 1'b0;
      hrdata = 32'hCAFE_F00D;
      mid();
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL er_gap got %0h exp 0", rsp_valid); end
      step();
      mid();
      vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin
         miscompares++; $display("FAIL er_second_rsp got v=%0h e=%0h d=%08h exp v=1 e=0 d=cafef00d", rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] addrs [2];
      logic [1:0]  sizes [2];
      addrs[0] = 32'h0000_0101; sizes[0] = 2'd2;
      addrs[1] = 32'h0000_0100; sizes[1] = 2'd3;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         drive_req(addrs[k], k == 0, sizes[k], 32'h1111_2222);
         mid();
         vectors++; if (htrans !== 2'd0) begin miscompares++; $display("FAIL ma%0d_htrans got %0h exp 0", k, htrans); end
         vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ma%0d_ready got %0h exp 1", k, req_ready); end
         step();
         req_valid = 1'b0;
         mid();
         vectors++; if (rsp_valid !== 1'b0 || htrans !== 2'd0) begin miscompares++; $display("FAIL ma%0d_gap got v=%0h t=%0h exp v=0 t=0", k, rsp_valid, htrans); end
         step();
         mid();
         vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            miscompares++; $display("FAIL ma%0d_rsp got v=%0h e=%0h d=%08h exp v=1 e=1 d=0", k, rsp_valid, rsp_err, rsp_rdata);
         end
         step();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_req(32'h0000_0080, 1'b1, 2'd2, 32'h55AA_55AA);
      mid();
      step();
      drive_req(32'h0000_0090, 1'b0, 2'd2, 32'h0);
      hready = 1'b0;
      mid();
      vectors++; if (hwdata !== 32'h55AA_55AA) begin miscompares++; $display("FAIL rm_hwdata_before got %08h exp 55aa55aa", hwdata); end
      #1 rst = 1'b1;
      #1;
      vectors++; if (hwdata !== 32'h0) begin miscompares++; $display("FAIL rm_hwdata_async got %08h exp 0", hwdata); end
      vectors++; if (htrans !== 2'd0 || req_ready !== 1'b0) begin miscompares++; $display("FAIL rm_bus_async got t=%0h r=%0h exp 0 0", htrans, req_ready); end
      step();
      step();
      rst = 1'b0;
      hready = 1'b1;
      req_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mid();
         vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rm_no_rsp%0d got %0h exp 0", k, rsp_valid); end
         step();
      end
      drive_req(32'h0000_0084, 1'b0, 2'd2, 32'h0);
      mid();
      vectors++; if (htrans !== 2'd2) begin miscompares++; $display("FAIL rm_new_htrans got %0h exp 2", htrans); end
      step();
      req_valid = 1'b0;
      hrdata = 32'h0BAD_CAFE;
      mid();
      step();
      mid();
      vectors++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0BAD_CAFE) begin
         miscompares++; $display("FAIL rm_new_rsp got v=%0h e=%0h d=%08h exp v=1 e=0 d=0badcafe", rsp_valid, rsp_err, rsp_rdata);
      end
   endtask

   task automatic test_random(input int n_cycles);
      logic [31:0] mem [16];
      logic        have_req, r_write, in_dp, d_write, d_local, err_second;
      logic [31:0] r_addr, r_wdata, d_addr, d_wdata;
      logic [1:0]  r_size, d_size;
      logic        rsp_pend, rsp_err_e, ok, mask, exp_ready;
      logic [31:0] rsp_rdata_e, placed, bmask;
      logic [1:0]  exp_htrans;
      int          lo, nbytes;
      do_reset();
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      have_req = 0; in_dp = 0; err_second = 0; rsp_pend = 0;
      r_write = 0; r_addr = 0; r_wdata = 0; r_size = 0;
      d_write = 0; d_local = 0; d_addr = 0; d_wdata = 0; d_size = 0;
      rsp_err_e = 0; rsp_rdata_e = 0;
      for (int c = 0; c < n_cycles; c++) begin
         if (!have_req && $urandom_range(3) != 0) begin
            have_req = 1;
            r_addr   = ($urandom_range(1) == 1 ? 32'hA000_0000 : 32'h0) | ($urandom & 32'h3F);
            r_write  = 1'($urandom_range(1));
            r_size   = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
            r_wdata  = $urandom;
         end
         hready = 1'b1;
         hresp  = 1'b0;
         hrdata = $urandom;
         if (in_dp && !d_local) begin
            if (err_second) begin
               hresp = 1'b1;
            end else if ($urandom_range(9) == 0) begin
               hready = 1'b0;
               hresp  = 1'b1;
            end else begin
               hready = ($urandom_range(3) != 0);
            end
            if (!d_write && !hresp) hrdata = mem[d_addr[5:2]];
         end
         req_valid = have_req;
         req_addr  = r_addr;
         req_write = r_write;
         req_size  = r_size;
         req_wdata = r_wdata;

         mask       = in_dp && hresp;
         ok         = (r_size != 2'd3) && (r_addr % (32'd1 << r_size) == 0);
         exp_ready  = hready && !mask;
         exp_htrans = (have_req && ok && !mask) ? 2'd2 : 2'd0;
         lo         = int'(d_addr[1:0]);
         nbytes     = 1 << d_size;
         if (d_size == 2'd0) begin
`ifdef AHB_INITIATOR_LANE_REPLICATE_EN
            placed = (d_wdata & 32'hFF) * 32'h0101_0101;
`else
            placed = (d_wdata & 32'hFF) << (8 * lo);
`endif
         end else if (d_size == 2'd1) begin
`ifdef AHB_INITIATOR_LANE_REPLICATE_EN
            placed = (d_wdata & 32'hFFFF) * 32'h0001_0001;
`else
            placed = (d_wdata & 32'hFFFF) << (8 * lo);
`endif
         end else begin
            placed = d_wdata;
         end

         mid();
         vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL rnd%0d_ready got %0h exp %0h", c, req_ready, exp_ready); end
         vectors++; if (htrans !== exp_htrans) begin miscompares++; $display("FAIL rnd%0d_htrans got %0h exp %0h", c, htrans, exp_htrans); end
         if (have_req) begin
            vectors++; if (haddr !== r_addr || hwrite !== r_write || hsize !== {1'b0, r_size}) begin
               miscompares++; $display("FAIL rnd%0d_addrphase got a=%08h w=%0h s=%0h exp a=%08h w=%0h s=%0h", c, haddr, hwrite, hsize, r_addr, r_write, r_size);
            end
         end
         if (in_dp && d_write && !d_local) begin
            vectors++; if (hwdata !== placed) begin miscompares++; $display("FAIL rnd%0d_hwdata got %08h exp %08h", c, hwdata, placed); end
         end
         vectors++; if (rsp_valid !== rsp_pend) begin miscompares++; $display("FAIL rnd%0d_rsp_valid got %0h exp %0h", c, rsp_valid, rsp_pend); end
         if (rsp_pend) begin
            vectors++; if (rsp_err !== rsp_err_e || rsp_rdata !== rsp_rdata_e) begin
               miscompares++; $display("FAIL rnd%0d_rsp got e=%0h d=%08h exp e=%0h d=%08h", c, rsp_err, rsp_rdata, rsp_err_e, rsp_rdata_e);
            end
         end

         rsp_pend = in_dp && hready;
         if (rsp_pend) begin
            rsp_err_e   = hresp || d_local;
            rsp_rdata_e = 32'h0;
            if (!rsp_err_e && !d_write) begin
               bmask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 1);
               rsp_rdata_e = (mem[d_addr[5:2]] >> (8 * lo)) & bmask;
            end
            if (!rsp_err_e && d_write) begin
               for (int k = lo; k < lo + nbytes; k++) mem[d_addr[5:2]][8*k +: 8] = placed[8*k +: 8];
            end
         end
         err_second = in_dp && !hready && hresp;
         if (have_req && exp_ready) begin
            in_dp    = 1;
            d_addr   = r_addr;
            d_write  = r_write;
            d_size   = r_size;
            d_wdata  = r_wdata;
            d_local  = !ok;
            have_req = 0;
         end else if (in_dp && hready) begin
            in_dp = 0;
         end
         step();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_word_write();
      test_byte_read_wait();
      test_half_write();
      test_error_back_to_back();
      test_misaligned();
      test_reset_mid();
      test_random(3000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ahb_lite_initiator.md
Name: ahb_lite_initiator

Overview:
- AHB3-Lite master that turns a simple valid/ready request stream from a core-side client (DMA, debug, test driver) into single NONSEQ transfers.
- Overlaps each address phase with the previous data phase. Returns one response per request: read data or error.
- Counterpart of the team's AHB RAM slaves; it drives the same signal set from the initiator side.

Parameters:
- AW, 32, address width of req_addr_i and m_haddr_o.
- HPROT, 4'b0011, constant driven on m_hprot_o (non-cacheable, non-bufferable, privileged, data).

Ports:
- s_clk_i  in  1  clock, rising edge.
- s_reset_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid; must hold, with all req fields stable, until accepted.
- req_ready_o  out  1  request accepted this cycle when valid&ready.
- req_addr_i  in  AW  byte address.
- req_write_i  in  1  1=write.
- req_size_i  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- req_wdata_i  in  32  right-aligned write data.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata_o  out  32  right-aligned, zero-extended read data; 0 for writes and errors.
- rsp_err_o  out  1  bus ERROR or local misalign/illegal-size error.
- m_haddr_o  out  AW  AHB address.
- m_htrans_o  out  2  IDLE(0) / NONSEQ(2) only.
- m_hwrite_o  out  1  AHB write.
- m_hsize_o  out  3  {1'b0,req_size_i}.
- m_hburst_o  out  3  constant SINGLE (0).
- m_hmastlock_o  out  1  constant 0.
- m_hprot_o  out  4  HPROT.
- m_hwdata_o  out  32  lane-placed write data, registered into data phase.
- m_hrdata_i  in  32  AHB read data.
- m_hready_i  in  1  AHB ready.
- m_hresp_i  in  1  AHB response; 1=ERROR.

Behaviour:
- Reset state: dp_valid=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, m_hwdata_o=0. m_htrans_o=IDLE and req_ready_o=0 while s_reset_i is high.
- Address phase drive is combinational from the request:
  - m_haddr_o, m_hwrite_o and m_hsize_o follow req_*.
  - m_htrans_o=NONSEQ iff req_valid_i & legal & aligned & ~err_mask.
  - Outputs are held stable while m_hready_i=0, because the request is held.
- Acceptance: req_ready_o = m_hready_i & ~err_mask.
- Error mask: err_mask = dp_valid & m_hresp_i. It covers both ERROR cycles.
  - First ERROR cycle (hready=0, hresp=1): m_htrans_o is forced to IDLE.
  - The pending request stays un-accepted and is re-driven after the error completes.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0.
- Local error (misaligned or size 3):
  - Accepted with htrans IDLE when req_ready_o=1.
  - Occupies the data-phase slot as local_err.
  - Completes on the next cycle with m_hready_i=1 and yields rsp_err_o=1.
  - No bus transfer occurs.
- Data-phase register: on acceptance, captures dp_valid=1, write, size, addr[1:0], local_err, and lane-placed wdata into m_hwdata_o. It is cleared when the data phase completes with no new acceptance.
- Completion: dp_valid & m_hready_i.
  - Next cycle: rsp_valid_o=1.
  - rsp_err_o = m_hresp_i | local_err.
  - rsp_rdata_o = lane-extracted m_hrdata_i for an OKAY read, else 0.
- Latency: accept at cycle N, zero-wait data phase at N+1, rsp_valid_o at N+2. Each slave wait state adds one cycle.
- Throughput: one request per cycle with zero-wait slaves. Back-to-back requests give back-to-back rsp pulses.
- Lane rules, write (default build): byte to lane addr[1:0]; half to lanes {addr[1],0}; other lanes 0. Word passes through.
- Lane rules, read: shift right by 8*addr[1:0], then mask to size (zero-extend).
- Reset mid-transfer: everything clears immediately. Any in-flight response is dropped and no rsp pulse is issued for it.

Optional Feature:
- Macro: AHB_INITIATOR_LANE_REPLICATE_EN.
- Defined: write data is replicated across all lanes. A byte is copied to all four lanes; a half is copied to both halves.
- Undefined: unused lanes are driven 0.
- Read path is unaffected in both builds.

Decomposition:
- Package ahb_pkg holds:
  - htrans codes: HTRANS_IDLE, HTRANS_NONSEQ.
  - hsize codes: HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD.
  - HBURST_SINGLE.
  - Typedef ahb_dphase_t (valid, write, size, addr_lo, local_err).
- One sub-module, ahb_lane_align: combinational write-lane placement and read extraction. The replicate macro is handled inside it.

Test Plan:
- Word write 0x0000_0010 data 0xDEADBEEF, zero-wait slave:
  - m_htrans_o=NONSEQ at N, m_hwdata_o=0xDEADBEEF at N+1.
  - rsp_valid_o at N+2, rsp_err_o=0.
- Byte read addr 0x...03, slave returns 0xAABBCCDD with 2 wait states:
  - address held stable while m_hready_i=0.
  - rsp_rdata_o=0x000000AA, rsp_valid_o at N+4.
- Half write 0xBEEF to addr 0x...02:
  - default build: m_hwdata_o=0xBEEF0000.
  - with AHB_INITIATOR_LANE_REPLICATE_EN: 0xBEEFBEEF.
- Slave ERROR on first of two back-to-back reads:
  - second read's htrans forced to IDLE during both error cycles.
  - first read returns rsp_err_o=1, rdata 0; second read is re-issued and returns OKAY.
- Word request to addr 0x...01:
  - no NONSEQ issued.
  - rsp_valid_o with rsp_err_o=1 two cycles after acceptance.
- Assert s_reset_i during a waited data phase:
  - outputs go to reset values asynchronously.
  - no rsp pulse for the in-flight request.
  - a new request after reset release completes normally.
